// File: rtl/core_pipe_ctrl.sv
// Pipeline sequencing controller for the KayRV32 core: stall/flush enables for
// IF/ID/EX, trap sequencing and a saturating stall-cycle counter.
module core_pipe_ctrl #(
  parameter int unsigned FLUSH_CYC    = 2,
  parameter int unsigned MEM_TIMEOUT  = 64,
  parameter bit          HALT_ON_TRAP = 1'b1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             i_Clk,
  input  logic             i_Rstn,
  input  logic [4:0]       i_IdRs1,
  input  logic             i_IdRs1Used,
  input  logic [4:0]       i_IdRs2,
  input  logic             i_IdRs2Used,
  input  logic [4:0]       i_ExRd,
  input  logic             i_ExIsLoad,
  input  logic             i_BrTaken,
  input  logic             i_Exception,
  input  logic             i_Event,
  input  logic             i_MemReq,
  input  logic             i_MemAck,
  output logic             o_StallIF,
  output logic             o_StallID,
  output logic             o_FlushID,
  output logic             o_FlushEX,
  output logic             o_Trap,
  output logic [1:0]       o_Cause,
  output logic             o_Halted,
  output logic [CNT_W-1:0] o_StallCnt
);

  localparam int unsigned FC_W = 3;
  localparam int unsigned WC_W = 8;

  typedef enum logic [2:0] {
    ST_RUN     = 3'd0,
    ST_MEMWAIT = 3'd1,
    ST_FLUSH   = 3'd2,
    ST_TRAP    = 3'd3,
    ST_HALT    = 3'd4
  } state_t;

  state_t            state, state_nxt;
  logic [FC_W-1:0]   flush_cnt, flush_cnt_nxt;
  logic [WC_W-1:0]   wait_cnt, wait_cnt_nxt;
  logic [1:0]        cause_q, cause_nxt;
  logic [CNT_W-1:0]  stall_cnt;
  logic              load_use, trap_req, mem_wait;
  logic              stall_if, stall_id, flush_id, flush_ex, trap, halted;

  assign load_use = i_ExIsLoad && (i_ExRd != 5'd0) &&
                    ((i_IdRs1Used && (i_IdRs1 == i_ExRd)) ||
                     (i_IdRs2Used && (i_IdRs2 == i_ExRd)));
  assign trap_req = i_Exception || i_Event;
  assign mem_wait = i_MemReq && !i_MemAck;

  // Next-state and stage-enable decode; RUN decisions act in the same cycle.
  always_comb begin
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    wait_cnt_nxt  = wait_cnt;
    cause_nxt     = cause_q;
    stall_if      = 1'b0;
    stall_id      = 1'b0;
    flush_id      = 1'b0;
    flush_ex      = 1'b0;
    trap          = 1'b0;
    halted        = 1'b0;
    case (state)
      ST_RUN: begin
        if (trap_req) begin
          flush_id  = 1'b1;
          flush_ex  = 1'b1;
          cause_nxt = i_Exception ? 2'd1 : 2'd2;
          state_nxt = ST_TRAP;
        end else if (i_BrTaken) begin
          flush_id      = 1'b1;
          flush_ex      = 1'b1;
          flush_cnt_nxt = FC_W'(FLUSH_CYC - 1);
          if (FLUSH_CYC > 1) state_nxt = ST_FLUSH;
        end else if (mem_wait) begin
          wait_cnt_nxt = '0;
          state_nxt    = ST_MEMWAIT;
        end else if (load_use) begin
          stall_if = 1'b1;
          stall_id = 1'b1;
        end
      end
      ST_MEMWAIT: begin
        if (i_MemAck) begin
          state_nxt = ST_RUN;
        end else begin
          stall_if     = 1'b1;
          stall_id     = 1'b1;
          wait_cnt_nxt = wait_cnt + WC_W'(1);
          if (wait_cnt == WC_W'(MEM_TIMEOUT - 1)) begin
            cause_nxt = 2'd3;
            state_nxt = ST_TRAP;
          end
        end
      end
      ST_FLUSH: begin
        flush_id = 1'b1;
        flush_ex = 1'b1;
        if (i_BrTaken) begin
          flush_cnt_nxt = FC_W'(FLUSH_CYC - 1);
        end else begin
          flush_cnt_nxt = (flush_cnt == '0) ? '0 : flush_cnt - FC_W'(1);
          if (flush_cnt <= FC_W'(1)) state_nxt = ST_RUN;
        end
      end
      ST_TRAP: begin
        trap      = 1'b1;
        stall_if  = 1'b1;
        flush_id  = 1'b1;
        flush_ex  = 1'b1;
        state_nxt = HALT_ON_TRAP ? ST_HALT : ST_RUN;
      end
      ST_HALT: begin
        halted   = 1'b1;
        stall_if = 1'b1;
        stall_id = 1'b1;
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  // Reset forces every enable low in the very cycle it is sampled.
  assign o_StallIF  = i_Rstn && stall_if;
  assign o_StallID  = i_Rstn && stall_id;
  assign o_FlushID  = i_Rstn && flush_id;
  assign o_FlushEX  = i_Rstn && flush_ex;
  assign o_Trap     = i_Rstn && trap;
  assign o_Halted   = i_Rstn && halted;
  assign o_Cause    = cause_q;
  assign o_StallCnt = stall_cnt;

  always_ff @(posedge i_Clk) begin
    if (!i_Rstn) begin
      state     <= ST_RUN;
      flush_cnt <= '0;
      wait_cnt  <= '0;
      cause_q   <= 2'd0;
      stall_cnt <= '0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_cnt_nxt;
      wait_cnt  <= wait_cnt_nxt;
      cause_q   <= cause_nxt;
      if (o_StallID && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule
